// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: command opcodes, request
// owner codes, FSM states and the word-address field layout
// {bank[1:0], row[11:0], col[7:0]}.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2
  } cmd_op_t;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_DISP = 3'd1,
    OWN_WR   = 3'd2,
    OWN_RD   = 3'd3,
    OWN_REF  = 3'd4
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int unsigned COL_W    = 8;
  localparam int unsigned COL_LSB  = 0;
  localparam int unsigned ROW_W    = 12;
  localparam int unsigned ROW_LSB  = 8;
  localparam int unsigned BANK_W   = 2;
  localparam int unsigned BANK_LSB = 20;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh scheduler: free-running tick counter plus a saturating
// count of refresh ticks not yet serviced.
//   clk, rst     : clock, asynchronous active-high reset
//   dec          : a refresh was granted this cycle
//   pending_ref  : outstanding refresh ticks (0..MAX_PENDING_REF)
module sdram_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES  = 750,
  parameter int unsigned MAX_PENDING_REF = 3,
  localparam int unsigned CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1,
  localparam int unsigned PEND_W = $clog2(MAX_PENDING_REF + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec,
  output logic [PEND_W-1:0] pending_ref
);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pending_ref <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      // tick and grant in the same cycle cancel out
      if (tick && !dec) begin
        if (pending_ref != PEND_W'(MAX_PENDING_REF))
          pending_ref <= pending_ref + PEND_W'(1);
      end else if (dec && !tick) begin
        if (pending_ref != '0)
          pending_ref <= pending_ref - PEND_W'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller command port between display
// burst fetches, MCU writes, MCU reads and auto-refresh; steers returned
// read words to the requester that owns the outstanding command.
//   clk, RST            : clock, asynchronous active-high reset
//   disp_*              : display burst-read request / ack / read strobe
//   wr_*                : MCU single-word write request / ack
//   rd_*                : MCU single-word read request / ack / read strobe
//   cmd_*               : command handshake towards the controller
//   ctrl_rvalid/rdata   : read word returned by the controller
//   ctrl_done           : controller finished the current command
//   rdata               : controller read data passthrough
//   busy                : a command is being issued or is outstanding
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 22,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned BURST_LEN       = 8,
  parameter int unsigned REFRESH_CYCLES  = 750,
  parameter int unsigned MAX_PENDING_REF = 3,
  parameter int unsigned DISP_STREAK     = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              disp_req,
  input  logic              disp_urgent,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_rvalid,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [3:0]        cmd_len,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              ctrl_rvalid,
  input  logic [DATA_W-1:0] ctrl_rdata,
  input  logic              ctrl_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int unsigned PEND_W   = $clog2(MAX_PENDING_REF + 1);
  localparam int unsigned STREAK_W = $clog2(DISP_STREAK + 1);

  state_t              state;
  owner_t              owner;
  owner_t              win;
  cmd_op_t             op_q;
  logic [STREAK_W-1:0] streak;
  logic [PEND_W-1:0]   pending_ref;
  logic                mcu_req;
  logic                ref_dec;

  assign mcu_req = wr_req | rd_req;

  sdram_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .MAX_PENDING_REF(MAX_PENDING_REF)
  ) u_refresh (
    .clk        (clk),
    .rst        (RST),
    .dec        (ref_dec),
    .pending_ref(pending_ref)
  );

  always_comb begin
    win = OWN_NONE;
    if (pending_ref == PEND_W'(MAX_PENDING_REF))
      win = OWN_REF;
    else if (disp_req && (streak < STREAK_W'(DISP_STREAK) || disp_urgent || !mcu_req))
      win = OWN_DISP;
    else if (pending_ref != '0 && !disp_req)
      win = OWN_REF;
    else if (wr_req)
      win = OWN_WR;
    else if (rd_req)
      win = OWN_RD;
  end

  assign ref_dec = (state == ST_IDLE) && (win == OWN_REF);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      cmd_valid <= 1'b0;
      op_q      <= OP_READ;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      cmd_wdata <= '0;
      streak    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win != OWN_NONE) begin
            state     <= ST_ISSUE;
            owner     <= win;
            cmd_valid <= 1'b1;
            case (win)
              OWN_REF: begin
                op_q      <= OP_REFRESH;
                cmd_addr  <= '0;
                cmd_len   <= '0;
                cmd_wdata <= '0;
              end
              OWN_DISP: begin
                op_q      <= OP_READ;
                cmd_addr  <= disp_addr;
                cmd_len   <= 4'(BURST_LEN);
                cmd_wdata <= '0;
                // streak only counts grants that made an MCU requester wait
                if (!mcu_req)
                  streak <= '0;
                else if (streak != STREAK_W'(DISP_STREAK))
                  streak <= streak + STREAK_W'(1);
              end
              OWN_WR: begin
                op_q      <= OP_WRITE;
                cmd_addr  <= wr_addr;
                cmd_len   <= 4'd1;
                cmd_wdata <= wr_data;
                streak    <= '0;
              end
              OWN_RD: begin
                op_q      <= OP_READ;
                cmd_addr  <= rd_addr;
                cmd_len   <= 4'd1;
                cmd_wdata <= '0;
                streak    <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            state     <= ST_WAIT;
            cmd_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (ctrl_done) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_op = op_q;

  // acks mark the accept cycle itself, so they follow cmd_ready directly
  assign disp_ack = cmd_valid && cmd_ready && (owner == OWN_DISP);
  assign wr_ack   = cmd_valid && cmd_ready && (owner == OWN_WR);
  assign rd_ack   = cmd_valid && cmd_ready && (owner == OWN_RD);

  assign disp_rvalid = (state == ST_WAIT) && ctrl_rvalid && (owner == OWN_DISP);
  assign rd_rvalid   = (state == ST_WAIT) && ctrl_rvalid && (owner == OWN_RD);

  assign rdata = ctrl_rdata;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          disp_req = 1'b0, disp_urgent = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_ack, disp_rvalid;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack, rd_rvalid;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          ctrl_rvalid, ctrl_done;
  logic          ctrl_rvalid_m = 1'b0, ctrl_rvalid_s = 1'b0;
  logic          ctrl_done_m = 1'b0, ctrl_done_s = 1'b0;
  logic [DW-1:0] ctrl_rdata = '0;
  logic [DW-1:0] rdata;
  logic          busy;

  assign ctrl_rvalid = ctrl_rvalid_m | ctrl_rvalid_s;
  assign ctrl_done   = ctrl_done_m | ctrl_done_s;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .BURST_LEN      (8),
    .REFRESH_CYCLES (750),
    .MAX_PENDING_REF(3),
    .DISP_STREAK    (4)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .disp_req   (disp_req),
    .disp_urgent(disp_urgent),
    .disp_addr  (disp_addr),
    .disp_ack   (disp_ack),
    .disp_rvalid(disp_rvalid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_rvalid  (rd_rvalid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_wdata  (cmd_wdata),
    .ctrl_rvalid(ctrl_rvalid),
    .ctrl_rdata (ctrl_rdata),
    .ctrl_done  (ctrl_done),
    .rdata      (rdata),
    .busy       (busy)
  );

  logic [1:0] pend_obs;
  assign pend_obs = dut.u_refresh.pending_ref;

  int checks = 0;
  int errors = 0;

  // Controller model state
  logic [15:0] rd_pattern = 16'h0000;
  logic [1:0]  acc_op;
  logic [3:0]  acc_len;

  // Monitor state
  int          disp_cnt = 0, rd_cnt = 0, max_pend = 0;
  logic [15:0] disp_last = '0, rd_last = '0;
  byte         grants[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    disp_req = 1'b0; disp_urgent = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    cmd_ready = 1'b1; ctrl_rvalid_s = 1'b0; ctrl_done_s = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      step();
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Controller model: reads return len words rd_pattern+i, then ctrl_done
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && !RST) begin
        acc_op  = cmd_op;
        acc_len = cmd_len;
        step();
        if (acc_op == 2'd0) begin
          for (int i = 0; i < int'(acc_len); i++) begin
            ctrl_rvalid_m = 1'b1;
            ctrl_rdata    = rd_pattern + 16'(i);
            step();
          end
        end
        ctrl_rvalid_m = 1'b0;
        ctrl_done_m   = 1'b1;
        step();
        ctrl_done_m   = 1'b0;
      end
    end
  end

  // Monitor: read-strobe counts, grant order, pending_ref high-water mark
  initial begin
    forever begin
      @(negedge clk);
      if (disp_rvalid) begin disp_cnt++; disp_last = rdata; end
      if (rd_rvalid)   begin rd_cnt++;   rd_last   = rdata; end
      if (int'(pend_obs) > max_pend) max_pend = int'(pend_obs);
      if (cmd_valid && cmd_ready) begin
        if (disp_ack)            grants.push_back("D");
        else if (wr_ack)         grants.push_back("W");
        else if (rd_ack)         grants.push_back("R");
        else if (cmd_op == 2'd2) grants.push_back("F");
        else                     grants.push_back("?");
      end
    end
  end

  initial begin
    int    n, base, dbase, rbase, f_cycle;
    string exp_s;

    // ---- reset state
    @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_op", cmd_op, 2'd0);
    chk("rst_cmd_addr", cmd_addr, 22'h0);
    chk("rst_cmd_len", cmd_len, 4'd0);
    chk("rst_cmd_wdata", cmd_wdata, 16'h0);
    chk("rst_acks", {disp_ack, wr_ack, rd_ack}, 3'b000);
    chk("rst_pend", pend_obs, 2'd0);

    // ---- 1: refresh after 750 idle cycles
    do_reset();
    repeat (749) step();
    @(negedge clk);
    chk("t1_pend_749", pend_obs, 2'd0);
    step();
    @(negedge clk);
    chk("t1_pend_750", pend_obs, 2'd1);
    chk("t1_valid_750", cmd_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t1_ref_valid", cmd_valid, 1'b1);
    chk("t1_ref_op", cmd_op, 2'd2);
    chk("t1_ref_len", cmd_len, 4'd0);
    chk("t1_ref_noack", {disp_ack, wr_ack, rd_ack}, 3'b000);
    chk("t1_pend_granted", pend_obs, 2'd0);
    wait_idle("t1_idle");

    // ---- 2: single write
    do_reset();
    wr_req = 1'b1; wr_addr = 22'h000123; wr_data = 16'h001F;
    @(negedge clk);
    chk("t2_valid_pre", cmd_valid, 1'b0);
    step();
    @(negedge clk);
    chk("t2_valid", cmd_valid, 1'b1);
    chk("t2_wr_ack", wr_ack, 1'b1);
    chk("t2_op", cmd_op, 2'd1);
    chk("t2_len", cmd_len, 4'd1);
    chk("t2_addr", cmd_addr, 22'h000123);
    chk("t2_wdata", cmd_wdata, 16'h001F);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t2_valid_drop", cmd_valid, 1'b0);
    chk("t2_ack_pulse", wr_ack, 1'b0);
    chk("t2_busy_wait", busy, 1'b1);
    wait_idle("t2_idle");

    // ---- 3: display streak vs waiting write, then urgent display
    do_reset();
    rd_pattern = 16'h3000;
    disp_addr = 22'h000100; wr_addr = 22'h000055; wr_data = 16'h0077;
    base = grants.size();
    disp_req = 1'b1; wr_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (grants.size() < base + 10 && n < 400) begin step(); @(negedge clk); n++; end
    disp_req = 1'b0; wr_req = 1'b0;
    chk("t3_grant_count_ok", grants.size() >= base + 10, 1'b1);
    exp_s = "DDDDWDDDDW";
    for (int i = 0; i < 10; i++)
      if (grants.size() > base + i)
        chk($sformatf("t3_grant_%0d", i), grants[base + i], exp_s[i]);
    wait_idle("t3_idle_a");
    base = grants.size();
    disp_urgent = 1'b1; disp_req = 1'b1; wr_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (grants.size() < base + 6 && n < 300) begin step(); @(negedge clk); n++; end
    disp_req = 1'b0; wr_req = 1'b0; disp_urgent = 1'b0;
    chk("t3u_grant_count_ok", grants.size() >= base + 6, 1'b1);
    for (int i = 0; i < 6; i++)
      if (grants.size() > base + i)
        chk($sformatf("t3u_grant_%0d", i), grants[base + i], "D");
    wait_idle("t3_idle_b");

    // ---- 4: MCU read routing and display burst routing
    do_reset();
    rd_pattern = 16'hA5A5;
    dbase = disp_cnt; rbase = rd_cnt;
    rd_req = 1'b1; rd_addr = 22'h002000;
    n = 0;
    @(negedge clk);
    while (!rd_ack && n < 20) begin step(); @(negedge clk); n++; end
    chk("t4_rd_ack", rd_ack, 1'b1);
    chk("t4_rd_op", cmd_op, 2'd0);
    chk("t4_rd_len", cmd_len, 4'd1);
    chk("t4_rd_addr", cmd_addr, 22'h002000);
    step();
    rd_req = 1'b0;
    wait_idle("t4_rd_idle");
    chk("t4_rd_rvalid_cnt", rd_cnt - rbase, 1);
    chk("t4_disp_rvalid_cnt", disp_cnt - dbase, 0);
    chk("t4_rd_rdata", rd_last, 16'hA5A5);
    ctrl_rvalid_s = 1'b1;
    #1;
    chk("t4_stray_rv_idle", {disp_rvalid, rd_rvalid}, 2'b00);
    ctrl_rvalid_s = 1'b0;
    rd_pattern = 16'h1000;
    dbase = disp_cnt; rbase = rd_cnt;
    disp_req = 1'b1; disp_addr = 22'h000108;
    n = 0;
    step();
    @(negedge clk);
    while (!disp_ack && n < 20) begin step(); @(negedge clk); n++; end
    chk("t4_disp_ack", disp_ack, 1'b1);
    chk("t4_disp_len", cmd_len, 4'd8);
    chk("t4_disp_addr", cmd_addr, 22'h000108);
    step();
    disp_req = 1'b0;
    wait_idle("t4_disp_idle");
    chk("t4_disp_rvalid_cnt", disp_cnt - dbase, 8);
    chk("t4_disp_no_rd", rd_cnt - rbase, 0);
    chk("t4_disp_last", disp_last, 16'h1007);

    // ---- 5: forced refresh preempts continuous display
    do_reset();
    rd_pattern = 16'h5000;
    disp_req = 1'b1; disp_addr = 22'h000200;
    f_cycle = 0;
    for (int c = 1; c <= 2400 && f_cycle == 0; c++) begin
      step();
      @(negedge clk);
      if (cmd_valid && cmd_ready && cmd_op == 2'd2) f_cycle = c;
    end
    chk("t5_forced_seen", f_cycle != 0, 1'b1);
    chk("t5_forced_window", (f_cycle >= 2251 && f_cycle <= 2265), 1'b1);
    chk("t5_pend_after", pend_obs, 2'd2);
    chk("t5_max_pend", max_pend, 3);
    disp_req = 1'b0;
    wait_idle("t5_idle");

    // ---- 6: async reset while stuck in ISSUE
    do_reset();
    cmd_ready = 1'b0;
    disp_req = 1'b1; disp_addr = 22'h000300;
    repeat (760) step();
    @(negedge clk);
    chk("t6_valid_held", cmd_valid, 1'b1);
    chk("t6_no_ack", disp_ack, 1'b0);
    chk("t6_busy", busy, 1'b1);
    chk("t6_pend", pend_obs, 2'd1);
    ctrl_done_s = 1'b1; ctrl_rvalid_s = 1'b1;
    #1;
    chk("t6_stray_rv_issue", disp_rvalid, 1'b0);
    step();
    ctrl_done_s = 1'b0; ctrl_rvalid_s = 1'b0;
    @(negedge clk);
    chk("t6_stray_done_issue", cmd_valid, 1'b1);
    #1;
    cmd_ready = 1'b1;
    #1;
    chk("t6_ack_accept", disp_ack, 1'b1);
    RST = 1'b1;
    #1;
    chk("t6_rst_valid", cmd_valid, 1'b0);
    chk("t6_rst_ack", disp_ack, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pend", pend_obs, 2'd0);
    chk("t6_rst_addr", cmd_addr, 22'h0);
    chk("t6_rst_len", cmd_len, 4'd0);
    disp_req = 1'b0; cmd_ready = 1'b0;
    step();
    RST = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port between three requesters: the TFT scan-out line fetch, MCU pixel writes from the 8080 bus, and MCU pixel reads.
- Also owns periodic auto-refresh scheduling.
- Sits between the bus/TFT front ends and the SDRAM command/datapath engine inside CPLD_TFT_V.
- Issues one command at a time and routes returned read data to the owning requester.

Parameters:
ADDR_W, 22, word address {bank[1:0], row[11:0], col[7:0]}
DATA_W, 16, pixel word width
BURST_LEN, 8, words per display fetch (power of 2, 1..8)
REFRESH_CYCLES, 750, clk cycles between refresh ticks (15 us at 50 MHz)
MAX_PENDING_REF, 3, refresh ticks that may be postponed before refresh is forced
DISP_STREAK, 4, consecutive display grants allowed while an MCU request waits

Ports:
clk  in  1  system clock
RST  in  1  asynchronous active-high reset
disp_req  in  1  display burst-read request, held until disp_ack
disp_urgent  in  1  display line FIFO below low-water mark
disp_addr  in  ADDR_W  burst start address (col aligned to BURST_LEN)
disp_ack  out  1  one-cycle pulse, command accepted by controller
disp_rvalid  out  1  read word valid for display
wr_req  in  1  MCU single-word write request, held until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse, write accepted
rd_req  in  1  MCU single-word read request, held until rd_ack
rd_addr  in  ADDR_W  read address
rd_ack  out  1  one-cycle pulse, read accepted
rd_rvalid  out  1  read word valid for MCU
cmd_valid  out  1  command to controller
cmd_ready  in  1  controller accepts command when cmd_valid&cmd_ready
cmd_op  out  2  0 = read, 1 = write, 2 = refresh
cmd_addr  out  ADDR_W  command address
cmd_len  out  4  words (1 or BURST_LEN; 0 for refresh)
cmd_wdata  out  DATA_W  write data
ctrl_rvalid  in  1  read word from controller
ctrl_done  in  1  one-cycle pulse, command fully complete
rdata  out  DATA_W  ctrl read data passthrough (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset values: all acks, rvalids and cmd_valid are 0; cmd_op/addr/len/wdata are 0; FSM is IDLE; pending_ref = 0; refresh timer = 0; streak = 0.
- Refresh timer:
  - Counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, pending_ref increments, saturating at MAX_PENDING_REF.
  - A refresh grant decrements pending_ref. A tick in the same cycle as a decrement nets to zero change.
- FSM has three states: IDLE, ISSUE, WAIT.
- IDLE: arbitration is evaluated every cycle. Winner by strict order:
  1. Forced refresh: pending_ref == MAX_PENDING_REF.
  2. Display: disp_req, and (streak < DISP_STREAK, or disp_urgent, or no MCU request).
  3. Normal refresh: pending_ref > 0, and no disp_req.
  4. wr_req.
  5. rd_req.
- On a winner, the command fields are registered, cmd_valid goes high next cycle, and the FSM goes to ISSUE.
- ISSUE: cmd_valid and all fields are held stable until cmd_ready.
  - In the accept cycle, the owner's ack pulses for one cycle (refresh has no ack).
  - The FSM goes to WAIT and cmd_valid drops the next cycle.
- WAIT: ctrl_rvalid is steered to disp_rvalid or rd_rvalid according to the registered owner. rvalid is combinational from ctrl_rvalid and owner.
  - ctrl_done returns the FSM to IDLE.
  - Minimum turnaround is IDLE→ISSUE→WAIT→IDLE, 3 cycles plus controller latency.
- streak rules:
  - Increments on each display grant while wr_req|rd_req is high.
  - Resets to 0 on any MCU grant, or on a display grant with no MCU request.
  - Saturates at DISP_STREAK.
- ctrl_rvalid outside WAIT, or on a write/refresh, is ignored.
- ctrl_done outside WAIT is ignored.
- A request dropped before its ack is not flagged. If it is dropped in ISSUE, the command still completes.
- Asynchronous RST mid-transaction aborts immediately to reset values. The controller is reset by the same RST.
- Requests are sampled only in IDLE. Arrivals during ISSUE/WAIT wait for the next arbitration.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - cmd_op encodings (OP_READ, OP_WRITE, OP_REFRESH);
  - owner encodings (OWN_NONE, OWN_DISP, OWN_WR, OWN_RD, OWN_REF);
  - address field widths and offsets for bank, row and col.
- One sub-module, sdram_refresh_timer: the tick counter plus the saturating pending_ref counter, with a dec input.

Test Plan:
1. Reset, idle for 750 cycles → pending_ref = 1 → refresh issued with cmd_op = 2; after ctrl_done, busy = 0.
2. wr_req addr 0x000123 data 0x001F, cmd_ready tied high → cmd_valid 1 cycle after request, wr_ack in the accept cycle, cmd_op = 1, cmd_len = 1.
3. disp_req and wr_req held continuously, disp_urgent = 0 → grants follow D,D,D,D,W,D,D,D,D,W. With disp_urgent = 1 → display only.
4. rd_req with controller returning 0xA5A5 → exactly one rd_rvalid with rdata = 0xA5A5, and disp_rvalid stays 0. Display burst → 8 disp_rvalid.
5. disp_req held continuously for 3×750 cycles → after the third tick a forced refresh preempts the display at the next IDLE; pending_ref never exceeds 3.
6. Assert RST while in ISSUE with cmd_ready = 0 → cmd_valid, acks and busy go to 0 asynchronously, and pending_ref = 0.
